// File: rtl/mem_stage_if.sv
// Bundle of EX->MEM, data-SRAM response and MEM->WB/decode signals.
interface mem_stage_if;
  logic        EX_MEM_valid;
  logic        MEM_allowin;
  logic [31:0] EX_pc;
  logic [38:0] EX_rf_bus;
  logic [4:0]  EX_ld_op;
  logic        EX_mem_req;
  logic [81:0] EX_except_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        WB_allowin;
  logic        WB_flush;
  logic        MEM_WB_valid;
  logic [31:0] MEM_pc;
  logic [38:0] MEM_rf_bus;
  logic [81:0] MEM_except_bus;
  logic        MEM_exc_pending;
  logic [38:0] MEM_fwd_bus;
  logic [31:0] mem_stall_cnt;

  modport master (
    output EX_MEM_valid, EX_pc, EX_rf_bus, EX_ld_op,
    output EX_mem_req, EX_except_bus,
    output data_sram_data_ok, data_sram_rdata,
    output WB_allowin, WB_flush,
    input  MEM_allowin, MEM_WB_valid, MEM_pc, MEM_rf_bus,
    input  MEM_except_bus, MEM_exc_pending, MEM_fwd_bus,
    input  mem_stall_cnt
  );

  modport slave (
    input  EX_MEM_valid, EX_pc, EX_rf_bus, EX_ld_op,
    input  EX_mem_req, EX_except_bus,
    input  data_sram_data_ok, data_sram_rdata,
    input  WB_allowin, WB_flush,
    output MEM_allowin, MEM_WB_valid, MEM_pc, MEM_rf_bus,
    output MEM_except_bus, MEM_exc_pending, MEM_fwd_bus,
    output mem_stall_cnt
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM response, aligns loads.
// Optional stall counter built when MEM_PERF_CNT_EN is defined.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus
);
  logic        mem_valid;
  logic [31:0] pc_r;
  logic [38:0] rf_bus_r;
  logic [4:0]  ld_op_r;
  logic        mem_req_r;
  logic [81:0] except_r;
  logic        resp_seen;
  logic [31:0] rdata_buf;
  logic        discard;

  logic        ready_go;
  logic        accept;
  logic        resp_hit;
  logic        discard_nxt;
  logic        load_wait;
  logic [31:0] alu_result;
  logic [1:0]  addr_lo;
  logic [31:0] ld_data;
  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] final_wdata;

  assign ready_go = ~mem_req_r | resp_seen
                  | (bus.data_sram_data_ok & ~discard);
  assign bus.MEM_allowin = ~mem_valid
                         | (ready_go & bus.WB_allowin);
  assign accept = bus.EX_MEM_valid & bus.MEM_allowin;
  assign resp_hit = bus.data_sram_data_ok & mem_valid
                  & mem_req_r & ~resp_seen & ~discard;

  // A squashed request still owes one data_ok; swallow it later.
  assign discard_nxt =
      (discard & ~bus.data_sram_data_ok)
    | (bus.WB_flush & mem_valid & mem_req_r & ~resp_seen
       & ~(bus.data_sram_data_ok & ~discard));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      pc_r      <= '0;
      rf_bus_r  <= '0;
      ld_op_r   <= '0;
      mem_req_r <= 1'b0;
      except_r  <= '0;
      resp_seen <= 1'b0;
      rdata_buf <= '0;
      discard   <= 1'b0;
    end else begin
      discard <= discard_nxt;
      if (bus.WB_flush) begin
        mem_valid <= 1'b0;
        resp_seen <= 1'b0;
      end else if (bus.MEM_allowin) begin
        mem_valid <= bus.EX_MEM_valid;
        if (accept) begin
          pc_r      <= bus.EX_pc;
          rf_bus_r  <= bus.EX_rf_bus;
          ld_op_r   <= bus.EX_ld_op;
          mem_req_r <= bus.EX_mem_req;
          except_r  <= bus.EX_except_bus;
          resp_seen <= 1'b0;
        end
      end else if (resp_hit) begin
        resp_seen <= 1'b1;
        rdata_buf <= bus.data_sram_rdata;
      end
    end
  end

  assign alu_result = rf_bus_r[31:0];
  assign addr_lo    = alu_result[1:0];
  assign ld_data    = resp_seen ? rdata_buf : bus.data_sram_rdata;
  assign ld_shift   = ld_data >> {addr_lo, 3'b000};
  assign ld_byte    = ld_shift[7:0];
  assign ld_half    = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    final_wdata = alu_result;
    unique case (1'b1)
      ld_op_r[0]: final_wdata = {{24{ld_byte[7]}}, ld_byte};
      ld_op_r[1]: final_wdata = {24'h0, ld_byte};
      ld_op_r[2]: final_wdata = {{16{ld_half[15]}}, ld_half};
      ld_op_r[3]: final_wdata = {16'h0, ld_half};
      ld_op_r[4]: final_wdata = ld_data;
      default:    final_wdata = alu_result;
    endcase
  end

  assign load_wait = mem_valid & (|ld_op_r) & ~ready_go;

  assign bus.MEM_WB_valid    = mem_valid & ready_go;
  assign bus.MEM_pc          = pc_r;
  assign bus.MEM_rf_bus      = {rf_bus_r[38:32], final_wdata};
  assign bus.MEM_except_bus  = except_r;
  assign bus.MEM_exc_pending = mem_valid & (except_r[2] | except_r[1]);
  assign bus.MEM_fwd_bus     = {load_wait, rf_bus_r[37] & mem_valid,
                                rf_bus_r[36:32], final_wdata};

`ifdef MEM_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (mem_valid & ~ready_go) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.mem_stall_cnt = stall_cnt;
`else
  assign bus.mem_stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Randomised and directed checks of mem_stage against a behavioural model.
module tb_mem_stage;
  logic clk;
  logic resetn;
  int   tests_run;
  int   fails;

  mem_stage_if bus ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(int k, logic [31:0] a,
                                           logic [31:0] w);
    int unsigned sh;
    int unsigned bv;
    int unsigned hv;
    sh = (a % 4) * 8;
    bv = (w >> sh) % 256;
    hv = (w >> sh) % 65536;
    case (k)
      0: return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
      1: return bv;
      2: return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
      3: return hv;
      default: return w;
    endcase
  endfunction

  task automatic clear_ex();
    bus.EX_MEM_valid  = 1'b0;
    bus.EX_pc         = '0;
    bus.EX_rf_bus     = '0;
    bus.EX_ld_op      = '0;
    bus.EX_mem_req    = 1'b0;
    bus.EX_except_bus = '0;
  endtask

  task automatic idle();
    clear_ex();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = '0;
    bus.WB_allowin        = 1'b1;
    bus.WB_flush          = 1'b0;
  endtask

  task automatic send(logic [31:0] pc, logic [38:0] rf,
                      logic [4:0] ld, logic req, logic [81:0] ex);
    bus.EX_MEM_valid  = 1'b1;
    bus.EX_pc         = pc;
    bus.EX_rf_bus     = rf;
    bus.EX_ld_op      = ld;
    bus.EX_mem_req    = req;
    bus.EX_except_bus = ex;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b0 || bus.MEM_allowin !== 1'b1) begin
      fails++;
      $display("FAIL reset_hs got wbv=%b allowin=%b exp 0 1",
               bus.MEM_WB_valid, bus.MEM_allowin);
    end
    tests_run++;
    if (bus.MEM_fwd_bus !== 39'h0 || bus.MEM_exc_pending !== 1'b0
        || bus.mem_stall_cnt !== 32'h0) begin
      fails++;
      $display("FAIL reset_out got fwd=%h exc=%b cnt=%h exp 0",
               bus.MEM_fwd_bus, bus.MEM_exc_pending, bus.mem_stall_cnt);
    end
    resetn = 1'b1;
  endtask

  task automatic test_ld_b();
    do_reset();
    @(negedge clk);
    send(32'h100, {1'b0, 1'b1, 5'd3, 32'h1003}, 5'b00001, 1'b1, '0);
    #1;
    tests_run++;
    if (bus.MEM_allowin !== 1'b1) begin
      fails++;
      $display("FAIL ldb_allowin got %b exp 1", bus.MEM_allowin);
    end
    @(negedge clk);
    clear_ex();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h80FF_0000;
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b1
        || bus.MEM_rf_bus !== {1'b0, 1'b1, 5'd3, 32'hFFFF_FF80}
        || bus.MEM_pc !== 32'h100) begin
      fails++;
      $display("FAIL ldb_data got v=%b rf=%h pc=%h exp 1 %h 100",
               bus.MEM_WB_valid, bus.MEM_rf_bus,
               bus.MEM_pc, {1'b0, 1'b1, 5'd3, 32'hFFFF_FF80});
    end
    @(negedge clk);
    bus.data_sram_data_ok = 1'b0;
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b0) begin
      fails++;
      $display("FAIL ldb_leave got %b exp 0", bus.MEM_WB_valid);
    end
  endtask

  task automatic test_ld_hu();
    logic [31:0] exp_cnt;
`ifdef MEM_PERF_CNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    @(negedge clk);
    send(32'h200, {1'b0, 1'b1, 5'd7, 32'h2002}, 5'b01000, 1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_ex();
      bus.data_sram_rdata = $urandom;
      #1;
      tests_run++;
      if (bus.MEM_fwd_bus[38] !== 1'b1 || bus.MEM_WB_valid !== 1'b0) begin
        fails++;
        $display("FAIL ldhu_wait%0d got lw=%b v=%b exp 1 0", i,
                 bus.MEM_fwd_bus[38], bus.MEM_WB_valid);
      end
    end
    @(negedge clk);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hBEEF_1234;
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b1 || bus.MEM_rf_bus[31:0] !== 32'h0000_BEEF
        || bus.MEM_fwd_bus[38] !== 1'b0) begin
      fails++;
      $display("FAIL ldhu_data got v=%b wd=%h lw=%b exp 1 0000beef 0",
               bus.MEM_WB_valid, bus.MEM_rf_bus[31:0],
               bus.MEM_fwd_bus[38]);
    end
    tests_run++;
    if (bus.mem_stall_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL ldhu_cnt got %0d exp %0d",
               bus.mem_stall_cnt, exp_cnt);
    end
    @(negedge clk);
    bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic test_wb_stall();
    do_reset();
    @(negedge clk);
    send(32'h300, {1'b0, 1'b1, 5'd9, 32'h3000}, 5'b10000, 1'b1, '0);
    @(negedge clk);
    clear_ex();
    bus.WB_allowin        = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h1234_5678;
    #1;
    tests_run++;
    if (bus.MEM_allowin !== 1'b0 || bus.MEM_WB_valid !== 1'b1
        || bus.MEM_rf_bus[31:0] !== 32'h1234_5678) begin
      fails++;
      $display("FAIL wbs_first got a=%b v=%b wd=%h exp 0 1 12345678",
               bus.MEM_allowin, bus.MEM_WB_valid, bus.MEM_rf_bus[31:0]);
    end
    @(negedge clk);
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (bus.MEM_allowin !== 1'b0 || bus.MEM_WB_valid !== 1'b1
        || bus.MEM_rf_bus[31:0] !== 32'h1234_5678) begin
      fails++;
      $display("FAIL wbs_held got a=%b v=%b wd=%h exp 0 1 12345678",
               bus.MEM_allowin, bus.MEM_WB_valid, bus.MEM_rf_bus[31:0]);
    end
    @(negedge clk);
    bus.WB_allowin = 1'b1;
    #1;
    tests_run++;
    if (bus.MEM_allowin !== 1'b1 || bus.MEM_rf_bus[31:0] !== 32'h1234_5678)
    begin
      fails++;
      $display("FAIL wbs_release got a=%b wd=%h exp 1 12345678",
               bus.MEM_allowin, bus.MEM_rf_bus[31:0]);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b0) begin
      fails++;
      $display("FAIL wbs_leave got %b exp 0", bus.MEM_WB_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    send(32'h400, {1'b0, 1'b1, 5'd4, 32'h4000}, 5'b10000, 1'b1, '0);
    @(negedge clk);
    clear_ex();
    bus.WB_flush = 1'b1;
    @(negedge clk);
    bus.WB_flush = 1'b0;
    send(32'h404, {1'b0, 1'b1, 5'd6, 32'h4004}, 5'b10000, 1'b1, '0);
    #1;
    tests_run++;
    if (bus.MEM_allowin !== 1'b1 || bus.MEM_WB_valid !== 1'b0) begin
      fails++;
      $display("FAIL fl_squash got a=%b v=%b exp 1 0",
               bus.MEM_allowin, bus.MEM_WB_valid);
    end
    @(negedge clk);
    clear_ex();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hAAAA_AAAA;
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b0 || bus.MEM_fwd_bus[38] !== 1'b1) begin
      fails++;
      $display("FAIL fl_discard got v=%b lw=%b exp 0 1",
               bus.MEM_WB_valid, bus.MEM_fwd_bus[38]);
    end
    @(negedge clk);
    bus.data_sram_rdata = 32'h5555_5555;
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b1 || bus.MEM_rf_bus[31:0] !== 32'h5555_5555
        || bus.MEM_pc !== 32'h404) begin
      fails++;
      $display("FAIL fl_newload got v=%b wd=%h pc=%h exp 1 55555555 404",
               bus.MEM_WB_valid, bus.MEM_rf_bus[31:0], bus.MEM_pc);
    end
    // Flush together with data_ok: response consumed, nothing to discard.
    @(negedge clk);
    idle();
    send(32'h500, {1'b0, 1'b1, 5'd8, 32'h5000}, 5'b10000, 1'b1, '0);
    @(negedge clk);
    clear_ex();
    bus.WB_flush          = 1'b1;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hCCCC_CCCC;
    @(negedge clk);
    idle();
    send(32'h504, {1'b0, 1'b1, 5'd8, 32'h5004}, 5'b10000, 1'b1, '0);
    @(negedge clk);
    clear_ex();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h0BAD_F00D;
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b1 || bus.MEM_rf_bus[31:0] !== 32'h0BAD_F00D)
    begin
      fails++;
      $display("FAIL fl_same_cycle got v=%b wd=%h exp 1 0badf00d",
               bus.MEM_WB_valid, bus.MEM_rf_bus[31:0]);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_alu_fwd();
    logic [81:0] ex;
    ex = {15'h1234, 32'hFFFF_0000, 32'hCAFE_0001, 3'b010};
    do_reset();
    @(negedge clk);
    send(32'h600, {1'b0, 1'b1, 5'd5, 32'h42}, 5'b00000, 1'b0, ex);
    @(negedge clk);
    clear_ex();
    #1;
    tests_run++;
    if (bus.MEM_fwd_bus !== {1'b0, 1'b1, 5'd5, 32'h42}
        || bus.MEM_WB_valid !== 1'b1) begin
      fails++;
      $display("FAIL alu_fwd got fwd=%h v=%b exp %h 1", bus.MEM_fwd_bus,
               bus.MEM_WB_valid, {1'b0, 1'b1, 5'd5, 32'h42});
    end
    tests_run++;
    if (bus.MEM_exc_pending !== 1'b1 || bus.MEM_except_bus !== ex) begin
      fails++;
      $display("FAIL alu_exc got p=%b ex=%h exp 1 %h",
               bus.MEM_exc_pending, bus.MEM_except_bus, ex);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.MEM_exc_pending !== 1'b0 || bus.MEM_WB_valid !== 1'b0) begin
      fails++;
      $display("FAIL alu_leave got p=%b v=%b exp 0 0",
               bus.MEM_exc_pending, bus.MEM_WB_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    send(32'h700, {1'b0, 1'b1, 5'd2, 32'h7000}, 5'b10000, 1'b1,
         82'h4);
    @(negedge clk);
    clear_ex();
    #1;
    tests_run++;
    if (bus.MEM_fwd_bus[38] !== 1'b1 || bus.MEM_exc_pending !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre got lw=%b p=%b exp 1 1",
               bus.MEM_fwd_bus[38], bus.MEM_exc_pending);
    end
    resetn = 1'b0;
    #1;
    tests_run++;
    if (bus.MEM_fwd_bus !== 39'h0 || bus.MEM_WB_valid !== 1'b0
        || bus.MEM_allowin !== 1'b1 || bus.MEM_exc_pending !== 1'b0
        || bus.MEM_pc !== 32'h0 || bus.MEM_rf_bus !== 39'h0) begin
      fails++;
      $display("FAIL arst_now got fwd=%h v=%b a=%b p=%b pc=%h exp 0 0 1 0 0",
               bus.MEM_fwd_bus, bus.MEM_WB_valid, bus.MEM_allowin,
               bus.MEM_exc_pending, bus.MEM_pc);
    end
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_random();
    int          kind;
    int          lat;
    int          stall;
    int          rdy;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] pc;
    logic [4:0]  wa;
    logic        csr;
    logic        we;
    logic        req;
    logic        isld;
    logic [4:0]  ldop;
    logic [38:0] exp_rf;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      kind  = $urandom_range(0, 6);
      lat   = $urandom_range(0, 3);
      stall = $urandom_range(0, 2);
      addr  = $urandom;
      if (kind == 2 || kind == 3) addr = addr - (addr % 2);
      if (kind == 4) addr = addr - (addr % 4);
      word = $urandom;
      pc   = $urandom;
      wa   = 5'($urandom);
      csr  = 1'($urandom);
      isld = (kind < 5);
      req  = (kind < 6);
      we   = (kind != 5);
      ldop = isld ? 5'(1 << kind) : 5'd0;
      rdy  = req ? lat : 0;
      exp_rf = {csr, we, wa, isld ? ref_load(kind, addr, word) : addr};
      @(negedge clk);
      idle();
      send(pc, {csr, we, wa, addr}, ldop, req, '0);
      #1;
      tests_run++;
      if (bus.MEM_allowin !== 1'b1) begin
        fails++;
        $display("FAIL rnd%0d_accept got %b exp 1", n, bus.MEM_allowin);
      end
      for (int c = 0; c <= rdy + stall; c++) begin
        @(negedge clk);
        clear_ex();
        bus.data_sram_data_ok = req && (c == lat);
        bus.data_sram_rdata   = (c == lat) ? word : $urandom;
        bus.WB_allowin        = (c >= rdy + stall);
        #1;
        tests_run++;
        if (bus.MEM_WB_valid !== (c >= rdy)
            || bus.MEM_fwd_bus[38] !== (isld && c < rdy)) begin
          fails++;
          $display("FAIL rnd%0d_c%0d_ctl got v=%b lw=%b exp %b %b", n, c,
                   bus.MEM_WB_valid, bus.MEM_fwd_bus[38],
                   c >= rdy, isld && c < rdy);
        end
        if (c >= rdy) begin
          tests_run++;
          if (bus.MEM_rf_bus !== exp_rf || bus.MEM_pc !== pc) begin
            fails++;
            $display("FAIL rnd%0d_c%0d_data k=%0d got rf=%h pc=%h exp %h %h",
                     n, c, kind, bus.MEM_rf_bus, bus.MEM_pc, exp_rf, pc);
          end
        end
      end
    end
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (bus.MEM_WB_valid !== 1'b0 || bus.MEM_allowin !== 1'b1) begin
      fails++;
      $display("FAIL rnd_drain got v=%b a=%b exp 0 1",
               bus.MEM_WB_valid, bus.MEM_allowin);
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    resetn    = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_ld_b();
    test_ld_hu();
    test_wb_stall();
    test_flush();
    test_alu_fwd();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
